// File: rtl/sparc_ifu_thrsched_pkg.sv
// Shared IFU thread-state definitions.
// Holds the 5-bit per-thread state encodings and the ready/running bit
// positions. Both the per-thread FSMs and the thread scheduler use them.
// It also holds small decode helpers built on those bits.
package sparc_ifu_thrsched_pkg;

   typedef enum logic [4:0] {
      THR_IDLE     = 5'b00000,
      THR_WAIT     = 5'b00001,
      THR_HALT     = 5'b00010,
      THR_RUN      = 5'b00101,
      THR_SPEC_RUN = 5'b00111,
      THR_SPEC_RDY = 5'b10011,
      THR_RDY      = 5'b11001
   } thr_state_e;

   localparam int THR_READY_BIT = 4;
   localparam int THR_RUN_BIT   = 2;

   // Any flavour of ready, speculative or not.
   function automatic logic thr_is_ready(input logic [4:0] st);
      return st[THR_READY_BIT];
   endfunction

   // Only the architecturally committed ready state.
   function automatic logic thr_is_nonspec_ready(input logic [4:0] st);
      return st == THR_RDY;
   endfunction

   function automatic logic thr_is_running(input logic [4:0] st);
      return st[THR_RUN_BIT];
   endfunction

endpackage

// File: rtl/sparc_ifu_rrpick4.sv
// Combinational 4-way round-robin picker.
//   req  : request vector, one bit per thread
//   last : index granted most recently; the search starts at last+1
//   gnt  : one-hot grant (all zero when there is no request)
//   idx  : encoded index of the grant (0 when there is no request)
module sparc_ifu_rrpick4 (
   input  logic [3:0] req,
   input  logic [1:0] last,
   output logic [3:0] gnt,
   output logic [1:0] idx
);

   logic [1:0] cand;
   logic       found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      // Offsets 1..4 visit every thread once, ending with 'last' itself.
      for (int k = 1; k <= 4; k++) begin
         cand = last + 2'(k);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/sparc_ifu_thrsched.sv
// Per-core IFU thread scheduler.
// It picks one ready thread round-robin, with non-speculative ready threads
// ahead of speculative ones, and sends it a one-cycle schedule pulse. It
// switches the running thread out on quantum expiry or on an fcl request.
// Ports:
//   clk, reset           : core clock, synchronous active-high reset
//   thr_state0..3 [4:0]  : current state of each thread FSM
//   switch_req           : fcl request to switch out the current thread (level)
//   sched_hold           : blocks new picks and switches while high
//   schedule [3:0]       : one-hot, one-cycle pulse to the incoming thread
//   switch_out           : one-cycle pulse; the current thread is switched out
//   curr_thr [1:0]       : thread owning the pipe
//   curr_vld             : curr_thr is valid
// All outputs are registered.
module sparc_ifu_thrsched
   import sparc_ifu_thrsched_pkg::*;
#(
   parameter int unsigned QUANTUM = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] thr_state0,
   input  logic [4:0] thr_state1,
   input  logic [4:0] thr_state2,
   input  logic [4:0] thr_state3,
   input  logic       switch_req,
   input  logic       sched_hold,
   output logic [3:0] schedule,
   output logic       switch_out,
   output logic [1:0] curr_thr,
   output logic       curr_vld
);

   typedef enum logic [1:0] {
      S_NONE,
      S_ISSUE,
      S_RUN,
      S_SWITCH
   } sched_state_e;

   localparam logic [7:0] QMAX = 8'(QUANTUM - 1);

   logic [4:0]   thr_state [4];
   logic [3:0]   rdy_vec;
   logic [3:0]   ns_rdy_vec;
   logic [3:0]   sp_rdy_vec;

   logic [3:0]   ns_gnt, sp_gnt, pick_gnt;
   logic [1:0]   ns_idx, sp_idx, pick_idx;

   sched_state_e state_reg, state_next;
   logic [1:0]   curr_thr_reg, curr_thr_next;
   logic [1:0]   last_thr_reg, last_thr_next;
   logic [7:0]   cnt_reg, cnt_next;
   logic [3:0]   schedule_reg, schedule_next;
   logic         switch_out_reg, switch_out_next;
   logic         curr_vld_reg, curr_vld_next;

   logic         other_rdy;
   logic         curr_running;

   assign thr_state[0] = thr_state0;
   assign thr_state[1] = thr_state1;
   assign thr_state[2] = thr_state2;
   assign thr_state[3] = thr_state3;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_decode
         assign rdy_vec[gi]    = thr_is_ready(thr_state[gi]);
         assign ns_rdy_vec[gi] = thr_is_nonspec_ready(thr_state[gi]);
         // Ready but not RDY means speculatively ready.
         assign sp_rdy_vec[gi] = rdy_vec[gi] & ~ns_rdy_vec[gi];
      end
   endgenerate

   sparc_ifu_rrpick4 u_pick_ns (
      .req  (ns_rdy_vec),
      .last (last_thr_reg),
      .gnt  (ns_gnt),
      .idx  (ns_idx)
   );

   sparc_ifu_rrpick4 u_pick_sp (
      .req  (sp_rdy_vec),
      .last (last_thr_reg),
      .gnt  (sp_gnt),
      .idx  (sp_idx)
   );

   // Any non-speculative candidate beats every speculative one.
   assign pick_gnt = (|ns_rdy_vec) ? ns_gnt : sp_gnt;
   assign pick_idx = (|ns_rdy_vec) ? ns_idx : sp_idx;

   assign other_rdy    = |(rdy_vec & ~(4'b0001 << curr_thr_reg));
   assign curr_running = thr_is_running(thr_state[curr_thr_reg]);

   always_comb begin
      state_next      = state_reg;
      curr_thr_next   = curr_thr_reg;
      last_thr_next   = last_thr_reg;
      cnt_next        = cnt_reg;
      schedule_next   = '0;
      switch_out_next = 1'b0;

      case (state_reg)
         S_NONE: begin
            if (!sched_hold && (|rdy_vec)) begin
               state_next    = S_ISSUE;
               curr_thr_next = pick_idx;
               last_thr_next = pick_idx;
               schedule_next = pick_gnt;
            end
         end
         S_ISSUE: begin
            cnt_next   = '0;
            state_next = S_RUN;
         end
         S_RUN: begin
            cnt_next = (cnt_reg == QMAX) ? cnt_reg : cnt_reg + 8'd1;
            // A stalled thread (or one that never reached RUN) releases the
            // pipe silently; there is nothing left to switch out.
            if (!curr_running) begin
               state_next = S_NONE;
            end else if (!sched_hold && other_rdy &&
                         (switch_req || (cnt_reg == QMAX))) begin
               state_next      = S_SWITCH;
               switch_out_next = 1'b1;
            end
         end
         S_SWITCH: begin
            state_next = S_NONE;
         end
         default: begin
            state_next = S_NONE;
         end
      endcase

      curr_vld_next = (state_next != S_NONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= S_NONE;
         curr_thr_reg   <= 2'd0;
         last_thr_reg   <= 2'd3;
         cnt_reg        <= '0;
         schedule_reg   <= '0;
         switch_out_reg <= 1'b0;
         curr_vld_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         curr_thr_reg   <= curr_thr_next;
         last_thr_reg   <= last_thr_next;
         cnt_reg        <= cnt_next;
         schedule_reg   <= schedule_next;
         switch_out_reg <= switch_out_next;
         curr_vld_reg   <= curr_vld_next;
      end
   end

   assign schedule   = schedule_reg;
   assign switch_out = switch_out_reg;
   assign curr_thr   = curr_thr_reg;
   assign curr_vld   = curr_vld_reg;

endmodule

// File: tb/tb_sparc_ifu_thrsched.sv
// Bench for sparc_ifu_thrsched: directed per-cycle vector table followed by
// randomized thread activity checked against a behavioural scheduler model.
module tb_sparc_ifu_thrsched;

   localparam int Q = 4;

   localparam logic [4:0] T_IDL = 5'b00000;
   localparam logic [4:0] T_WT  = 5'b00001;
   localparam logic [4:0] T_RDY = 5'b11001;
   localparam logic [4:0] T_SRD = 5'b10011;
   localparam logic [4:0] T_RUN = 5'b00101;
   localparam logic [4:0] T_SRN = 5'b00111;

   logic       clk;
   logic       tb_rst;
   logic [4:0] tb_st [4];
   logic       tb_req;
   logic       tb_hold;
   logic [3:0] schedule;
   logic       switch_out;
   logic [1:0] curr_thr;
   logic       curr_vld;

   int n_vec;
   int n_miss;

   sparc_ifu_thrsched #(.QUANTUM(Q)) dut (
      .clk        (clk),
      .reset      (tb_rst),
      .thr_state0 (tb_st[0]),
      .thr_state1 (tb_st[1]),
      .thr_state2 (tb_st[2]),
      .thr_state3 (tb_st[3]),
      .switch_req (tb_req),
      .sched_hold (tb_hold),
      .schedule   (schedule),
      .switch_out (switch_out),
      .curr_thr   (curr_thr),
      .curr_vld   (curr_vld)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural scheduler model ----------------
   // Ownership is tracked as "pipe owned", "pulse being issued", and
   // "switch being signalled", plus elapsed run cycles since the issue.
   logic       m_vld, m_iss, m_sw;
   logic [1:0] m_thr, m_last;
   int         m_elapsed;

   function automatic bit model_pick(output logic [1:0] p);
      p = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         int t;
         t = (int'(m_last) + i) % 4;
         if (tb_st[t] == T_RDY) begin p = 2'(t); return 1'b1; end
      end
      for (int i = 1; i <= 4; i++) begin
         int t;
         t = (int'(m_last) + i) % 4;
         if (tb_st[t][4]) begin p = 2'(t); return 1'b1; end
      end
      return 1'b0;
   endfunction

   task automatic model_step();
      logic [1:0] p;
      bit         other;
      if (tb_rst) begin
         m_vld = 0; m_iss = 0; m_sw = 0; m_thr = 0; m_last = 3; m_elapsed = 0;
      end else if (!m_vld) begin
         if (!tb_hold && model_pick(p)) begin
            m_thr = p; m_last = p; m_vld = 1; m_iss = 1;
         end
      end else if (m_iss) begin
         m_iss = 0; m_elapsed = 0;
      end else if (m_sw) begin
         m_sw = 0; m_vld = 0;
      end else begin
         other = 0;
         for (int i = 0; i < 4; i++)
            if (i != int'(m_thr) && tb_st[i][4]) other = 1;
         if (!tb_st[m_thr][2]) m_vld = 0;
         else if (!tb_hold && other && (tb_req || m_elapsed >= Q - 1)) m_sw = 1;
         m_elapsed++;
      end
   endtask

   function automatic logic [3:0] m_sched();
      return m_iss ? (4'b0001 << m_thr) : 4'b0000;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       rst;
      logic [4:0] s0, s1, s2, s3;
      logic       req, hold;
      logic [3:0] e_sched;
      logic       e_sw, e_vld;
      logic [1:0] e_thr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rst, logic [4:0] s0, logic [4:0] s1,
                               logic [4:0] s2, logic [4:0] s3, logic req,
                               logic hold, logic [3:0] es, logic esw,
                               logic ev, logic [1:0] et);
      vec_t v;
      v.rst = rst; v.s0 = s0; v.s1 = s1; v.s2 = s2; v.s3 = s3;
      v.req = req; v.hold = hold;
      v.e_sched = es; v.e_sw = esw; v.e_vld = ev; v.e_thr = et;
      return v;
   endfunction

   task automatic check(string name, int idx, logic [3:0] es, logic esw,
                        logic ev, logic [1:0] et);
      n_vec++;
      if (schedule !== es || switch_out !== esw || curr_vld !== ev || curr_thr !== et) begin
         n_miss++;
         $display("FAIL %s #%0d: got sched=%b sw=%b vld=%b thr=%0d, want sched=%b sw=%b vld=%b thr=%0d",
                  name, idx, schedule, switch_out, curr_vld, curr_thr, es, esw, ev, et);
      end else begin
         $display("%s #%0d ok: sched=%b sw=%b vld=%b thr=%0d",
                  name, idx, schedule, switch_out, curr_vld, curr_thr);
      end
   endtask

   logic [3:0] p_sched;
   logic       p_sw;
   logic [1:0] p_thr;

   initial begin
      n_vec = 0; n_miss = 0;
      tb_rst = 1'b1; tb_req = 1'b0; tb_hold = 1'b0;
      for (int i = 0; i < 4; i++) tb_st[i] = T_IDL;
      m_vld = 0; m_iss = 0; m_sw = 0; m_thr = 0; m_last = 3; m_elapsed = 0;

      // Round-robin from reset with quantum expiry.
      vecs.push_back(mk(1, T_IDL, T_IDL, T_IDL, T_IDL, 0, 0, 4'b0000, 0, 0, 0));
      vecs.push_back(mk(0, T_RDY, T_RDY, T_RDY, T_RDY, 0, 0, 4'b0001, 0, 1, 0));
      vecs.push_back(mk(0, T_RDY, T_RDY, T_RDY, T_RDY, 0, 0, 4'b0000, 0, 1, 0));
      for (int i = 0; i < Q - 1; i++)
         vecs.push_back(mk(0, T_RUN, T_RDY, T_RDY, T_RDY, 0, 0, 4'b0000, 0, 1, 0));
      vecs.push_back(mk(0, T_RUN, T_RDY, T_RDY, T_RDY, 0, 0, 4'b0000, 1, 1, 0));
      vecs.push_back(mk(0, T_RUN, T_RDY, T_RDY, T_RDY, 0, 0, 4'b0000, 0, 0, 0));
      vecs.push_back(mk(0, T_RDY, T_RDY, T_RDY, T_RDY, 0, 0, 4'b0010, 0, 1, 1));
      // Thread 0 never reaches RUN; then nonspec thread 3 beats spec thread 1.
      vecs.push_back(mk(1, T_IDL, T_IDL, T_IDL, T_IDL, 0, 0, 4'b0000, 0, 0, 0));
      vecs.push_back(mk(0, T_RDY, T_IDL, T_IDL, T_IDL, 0, 0, 4'b0001, 0, 1, 0));
      vecs.push_back(mk(0, T_WT,  T_IDL, T_IDL, T_IDL, 0, 0, 4'b0000, 0, 1, 0));
      vecs.push_back(mk(0, T_WT,  T_SRD, T_IDL, T_RDY, 0, 0, 4'b0000, 0, 0, 0));
      vecs.push_back(mk(0, T_WT,  T_SRD, T_IDL, T_RDY, 0, 0, 4'b1000, 0, 1, 3));
      // Thread 2 alone runs past saturation; thread 0 becoming ready forces a switch.
      vecs.push_back(mk(1, T_IDL, T_IDL, T_IDL, T_IDL, 0, 0, 4'b0000, 0, 0, 0));
      vecs.push_back(mk(0, T_IDL, T_IDL, T_RDY, T_IDL, 0, 0, 4'b0100, 0, 1, 2));
      vecs.push_back(mk(0, T_IDL, T_IDL, T_RDY, T_IDL, 0, 0, 4'b0000, 0, 1, 2));
      for (int i = 0; i < Q + 1; i++)
         vecs.push_back(mk(0, T_IDL, T_IDL, T_RUN, T_IDL, 0, 0, 4'b0000, 0, 1, 2));
      vecs.push_back(mk(0, T_RDY, T_IDL, T_RUN, T_IDL, 0, 0, 4'b0000, 1, 1, 2));
      vecs.push_back(mk(0, T_RDY, T_IDL, T_RUN, T_IDL, 0, 0, 4'b0000, 0, 0, 2));
      vecs.push_back(mk(0, T_RDY, T_IDL, T_RDY, T_IDL, 0, 0, 4'b0001, 0, 1, 0));
      // Running thread stalls mid-quantum: silent release, one idle cycle.
      vecs.push_back(mk(0, T_RDY, T_IDL, T_RDY, T_IDL, 0, 0, 4'b0000, 0, 1, 0));
      vecs.push_back(mk(0, T_RUN, T_IDL, T_RDY, T_IDL, 0, 0, 4'b0000, 0, 1, 0));
      vecs.push_back(mk(0, T_WT,  T_IDL, T_RDY, T_IDL, 0, 0, 4'b0000, 0, 0, 0));
      vecs.push_back(mk(0, T_WT,  T_IDL, T_RDY, T_IDL, 0, 0, 4'b0100, 0, 1, 2));
      // Hold blocks a requested switch and a new pick.
      vecs.push_back(mk(0, T_WT,  T_IDL, T_RDY, T_IDL, 0, 0, 4'b0000, 0, 1, 2));
      vecs.push_back(mk(0, T_RDY, T_IDL, T_RUN, T_IDL, 1, 1, 4'b0000, 0, 1, 2));
      vecs.push_back(mk(0, T_RDY, T_IDL, T_RUN, T_IDL, 1, 1, 4'b0000, 0, 1, 2));
      vecs.push_back(mk(0, T_RDY, T_IDL, T_RUN, T_IDL, 1, 0, 4'b0000, 1, 1, 2));
      vecs.push_back(mk(0, T_RDY, T_IDL, T_RUN, T_IDL, 1, 0, 4'b0000, 0, 0, 2));
      vecs.push_back(mk(0, T_RDY, T_IDL, T_RDY, T_IDL, 0, 1, 4'b0000, 0, 0, 2));
      vecs.push_back(mk(0, T_RDY, T_IDL, T_RDY, T_IDL, 0, 0, 4'b0001, 0, 1, 0));
      // Reset during the issue cycle kills the pulse and restores last_thr.
      vecs.push_back(mk(1, T_RDY, T_IDL, T_RDY, T_IDL, 0, 0, 4'b0000, 0, 0, 0));
      vecs.push_back(mk(0, T_IDL, T_IDL, T_IDL, T_IDL, 0, 0, 4'b0000, 0, 0, 0));
      vecs.push_back(mk(0, T_RDY, T_RDY, T_RDY, T_RDY, 0, 0, 4'b0001, 0, 1, 0));

      foreach (vecs[vi]) begin
         tb_rst = vecs[vi].rst;
         tb_st[0] = vecs[vi].s0; tb_st[1] = vecs[vi].s1;
         tb_st[2] = vecs[vi].s2; tb_st[3] = vecs[vi].s3;
         tb_req = vecs[vi].req; tb_hold = vecs[vi].hold;
         tick();
         check("dir", vi, vecs[vi].e_sched, vecs[vi].e_sw, vecs[vi].e_vld, vecs[vi].e_thr);
      end

      // ---------------- randomized phase ----------------
      tb_rst = 1'b1; tb_req = 1'b0; tb_hold = 1'b0;
      for (int i = 0; i < 4; i++) tb_st[i] = T_IDL;
      tick();
      check("rnd_reset", 0, m_sched(), m_sw, m_vld, m_thr);
      p_sched = m_sched(); p_sw = m_sw; p_thr = m_thr;

      for (int cyc = 1; cyc <= 1500; cyc++) begin
         // Thread FSM behaviour: react to last cycle's pulses, plus random events.
         for (int i = 0; i < 4; i++) begin
            logic [4:0] ns;
            int         r;
            ns = tb_st[i];
            if (p_sched[i]) begin
               if (tb_st[i] == T_RDY) ns = T_RUN;
               else if (tb_st[i] == T_SRD) ns = T_SRN;
            end else if (p_sw && int'(p_thr) == i) begin
               if (tb_st[i] == T_RUN) ns = T_RDY;
               else if (tb_st[i] == T_SRN) ns = T_SRD;
            end
            r = int'($urandom_range(0, 99));
            case (tb_st[i])
               T_RUN, T_SRN: if (r < 6) ns = T_WT;
               T_WT:         if (r < 20) ns = (r < 14) ? T_RDY : T_SRD;
               T_IDL:        if (r < 10) ns = T_RDY;
               T_SRD:        if (r < 5) ns = T_RDY;
               T_RDY:        if (r < 3) ns = T_WT;
               default:      ;
            endcase
            tb_st[i] = ns;
         end
         tb_req  = ($urandom_range(0, 3) == 0);
         tb_hold = ($urandom_range(0, 9) == 0);
         tb_rst  = ($urandom_range(0, 199) == 0);
         tick();
         check("rnd", cyc, m_sched(), m_sw, m_vld, m_thr);
         n_vec++;
         if (!$onehot0(schedule) || (|schedule && switch_out)) begin
            n_miss++;
            $display("FAIL rnd_excl #%0d: got sched=%b sw=%b, want at most one pulse",
                     cyc, schedule, switch_out);
         end
         p_sched = m_sched(); p_sw = m_sw; p_thr = m_thr;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
